// File: rtl/riscv_div_unit.sv
// rtl/riscv_div_unit.sv - multi-cycle RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
module riscv_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] div_q;
    logic [5:0]  cnt;
    logic [63:0] rq;
    logic        neg_q;
    logic        neg_r;

    logic        in_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] trial;
    logic [31:0] q_final;
    logic [31:0] r_final;

    // Operand magnitudes at capture, the trial subtraction and the sign fix-up of the results
    always_comb begin
        in_signed = ~op[0];
        a_neg     = in_signed & dividend[31];
        b_neg     = in_signed & divisor[31];
        a_mag     = a_neg ? (~dividend + 32'd1) : dividend;
        b_mag     = b_neg ? (~divisor + 32'd1) : divisor;
        // Upper 33 bits of the pair after the shift, minus {0, divisor}, as add of inverse plus one
        trial     = rq[63:31] + {1'b1, ~div_q} + 33'd1;
        q_final   = neg_q ? (~rq[31:0] + 32'd1) : rq[31:0];
        // With a zero divisor every step succeeds, so the remainder is the dividend magnitude
        // and the neg_r fix-up restores the original dividend without a separate path
        r_final   = neg_r ? (~rq[63:32] + 32'd1) : rq[63:32];
    end

    // Control FSM and datapath registers; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            div_q  <= 32'd0;
            cnt    <= 6'd0;
            rq     <= 64'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        div_q <= b_mag;
                        cnt   <= 6'd0;
                        rq    <= {32'd0, a_mag};
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (!trial[32]) begin
                        rq <= {trial[31:0], rq[30:0], 1'b1};
                    end else begin
                        rq <= {rq[62:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_q[1]) begin
                        result <= r_final;
                    end else if (div_q == 32'd0) begin
                        result <= 32'hFFFF_FFFF;
                    end else begin
                        result <= q_final;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div_unit.sv
// tb/tb_riscv_div_unit.sv - directed self-checking bench for riscv_div_unit
module tb_riscv_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_total;
    int n_pass;

    riscv_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op in cycle 0, scramble inputs afterwards, check timing and result
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int done_cyc;
        int n_done;
        logic busy_ok;
        logic [31:0] res34;
        @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        done_cyc = -1; n_done = 0; busy_ok = 1'b1; res34 = 32'd0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; op = ~o; dividend = 32'h5A5A_A5A5; divisor = 32'd3;
            end
            if (done === 1'b1) begin
                n_done++; done_cyc = c;
            end
            if (busy !== (c <= 33)) busy_ok = 1'b0;
            if (c == 34) res34 = result;
        end
        check({tag, "_result"}, res34, exp);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'd34);
        check({tag, "_done_count"}, 32'(n_done), 32'd1);
        check({tag, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        int n_done;
        int first_done;
        int second_done;
        logic [31:0] r1;
        logic [31:0] r2;

        n_total = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        do_op(2'b01, 32'd100, 32'd7, 32'd14, "divu_100_7");
        do_op(2'b11, 32'd100, 32'd7, 32'd2, "remu_100_7");
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, "div_m7_m2");
        do_op(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "rem_m7_m2");
        do_op(2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "div_by0");
        do_op(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        do_op(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, "rem_by0");
        do_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, "remu_by0");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_neg_by0");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
        do_op(2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, "divu_big");

        // start held high with changing operands, second op accepted in cycle 35
        @(negedge clk);
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk);
        n_done = 0; first_done = -1; second_done = -1; r1 = 32'd0; r2 = 32'd0;
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = c; else second_done = c;
            end
            if (c == 34) r1 = result;
            if (c == 69) r2 = result;
            if (c < 34) begin
                op = 2'(c); dividend = 32'h0BAD_0000 + 32'(c); divisor = 32'd1;
            end else if (c == 34) begin
                op = 2'b11; dividend = 32'd100; divisor = 32'd7;
            end else if (c == 36) begin
                start = 1'b0; op = 2'b00; dividend = 32'd1; divisor = 32'd1;
            end
        end
        check("hold_first_done", 32'(first_done), 32'd34);
        check("hold_first_result", r1, 32'd14);
        check("b2b_second_done", 32'(second_done), 32'd69);
        check("b2b_second_result", r2, 32'd2);
        check("hold_done_count", 32'(n_done), 32'd2);

        // reset in cycle 10 discards the operation
        @(negedge clk);
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        n_done = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                check("rst_mid_busy", {31'd0, busy}, 32'd0);
                check("rst_mid_done", {31'd0, done}, 32'd0);
                check("rst_mid_result", result, 32'd0);
                rst = 1'b0;
            end
            if (done === 1'b1) n_done++;
        end
        check("rst_no_done", 32'(n_done), 32'd0);
        do_op(2'b01, 32'd1000, 32'd10, 32'd100, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
